// File: rtl/note_hit_judge.sv
// Judges detected pitch against the score window's oldest slot once per eighth note,
// and keeps score, streak, best streak and a streak-driven multiplier.
module note_hit_judge #(
  parameter int HOLD_CYCLES    = 1000000,
  parameter int POINTS_PER_HIT = 10,
  parameter int STREAK_STEP    = 8,
  parameter int MAX_MULT       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        song_start,
  input  logic        eighth_note_enable,
  input  logic [63:0] next_notes,
  input  logic [3:0]  played_note,
  input  logic        played_valid,
  output logic [3:0]  target_note,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [7:0]  max_streak,
  output logic [2:0]  mult
);

  // state       | meaning
  // IDLE        | no song running, target cleared
  // WAIT_STROBE | song started, waiting for the first window shift
  // LOAD        | latch the oldest window slot as the new target
  // ARMED       | counting consecutive matching cycles
  // DONE        | slot already hit, ignore input until next strobe
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_STROBE = 3'd1,
    LOAD        = 3'd2,
    ARMED       = 3'd3,
    DONE        = 3'd4
  } state_t;

  localparam logic [19:0] HOLD_LAST = 20'(HOLD_CYCLES - 1);
  localparam logic [7:0]  STEP8     = 8'(STREAK_STEP);
  localparam logic [7:0]  MAX8      = 8'(MAX_MULT);
  localparam logic [16:0] PTS17     = 17'(POINTS_PER_HIT);

  state_t      state, state_nxt;
  logic [19:0] hold_cnt, hold_nxt;
  logic        match;
  logic        do_hit;
  logic        do_miss;
  logic        load_tgt;
  logic [7:0]  mult_full;
  logic [16:0] pts;
  logic [16:0] sum;
  logic [15:0] score_sat;
  logic [7:0]  streak_inc;

  // Only the slot being played matters here; the rest of the window feeds the display.
  logic unused_window;
  assign unused_window = ^next_notes[59:0];

  assign match = played_valid && (played_note == target_note) && (target_note != 4'd0);

  assign mult_full = 8'd1 + (streak / STEP8);
  assign mult      = (mult_full > MAX8) ? 3'(MAX_MULT) : mult_full[2:0];

  assign pts        = PTS17 * {14'd0, mult};
  assign sum        = {1'b0, score} + pts;
  assign score_sat  = sum[16] ? 16'hFFFF : sum[15:0];
  assign streak_inc = (streak == 8'hFF) ? 8'hFF : streak + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= 20'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    load_tgt  = 1'b0;
    if (song_start) begin
      state_nxt = WAIT_STROBE;
      hold_nxt  = 20'd0;
    end else begin
      case (state)
        IDLE: ;
        WAIT_STROBE: begin
          if (eighth_note_enable) state_nxt = LOAD;
        end
        LOAD: begin
          load_tgt  = 1'b1;
          hold_nxt  = 20'd0;
          state_nxt = ARMED;
        end
        ARMED: begin
          if (match) begin
            if (hold_cnt == HOLD_LAST) begin
              do_hit    = 1'b1;
              hold_nxt  = 20'd0;
              state_nxt = DONE;
            end else begin
              hold_nxt = hold_cnt + 20'd1;
            end
          end else begin
            hold_nxt = 20'd0;
          end
          // A hit completing on the strobe cycle still counts; only unhit slots miss.
          if (eighth_note_enable) begin
            do_miss   = !do_hit && (target_note != 4'd0);
            state_nxt = LOAD;
          end
        end
        DONE: begin
          if (eighth_note_enable) state_nxt = LOAD;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_note <= 4'd0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      score       <= 16'd0;
      streak      <= 8'd0;
      max_streak  <= 8'd0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (song_start) begin
        score      <= 16'd0;
        streak     <= 8'd0;
        max_streak <= 8'd0;
      end else begin
        if (load_tgt) target_note <= next_notes[63:60];
        if (do_hit) begin
          hit_pulse <= 1'b1;
          score     <= score_sat;
          streak    <= streak_inc;
          if (streak_inc > max_streak) max_streak <= streak_inc;
        end
        if (do_miss) begin
          miss_pulse <= 1'b1;
          streak     <= 8'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_hit_judge.sv
// Self-checking bench for note_hit_judge: directed scenarios plus random play,
// compared each cycle against a slot-level behavioural model.
module tb_note_hit_judge;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        song_start = 1'b0;
  logic        eighth_note_enable = 1'b0;
  logic [63:0] next_notes = 64'd0;
  logic [3:0]  played_note = 4'd0;
  logic        played_valid = 1'b0;
  logic [3:0]  target_note;
  logic        hit_pulse, miss_pulse;
  logic [15:0] score;
  logic [7:0]  streak, max_streak;
  logic [2:0]  mult;

  int checks = 0;
  int failures = 0;
  int hit_seen = 0;
  int miss_seen = 0;
  bit chk_en = 1'b0;

  note_hit_judge #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .reset(reset), .song_start(song_start),
    .eighth_note_enable(eighth_note_enable), .next_notes(next_notes),
    .played_note(played_note), .played_valid(played_valid),
    .target_note(target_note), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .streak(streak), .max_streak(max_streak), .mult(mult)
  );

  always #5 clk = ~clk;

  // Behavioural model: song/slot bookkeeping with plain integers.
  int       m_score, m_streak, m_max, m_run;
  logic [3:0] m_tgt;
  bit       m_active, m_first, m_load, m_judged, m_hit, m_miss;

  function automatic int mult_of(input int s);
    int m;
    m = 1 + s / 8;
    return (m > 4) ? 4 : m;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_score = 0; m_streak = 0; m_max = 0; m_run = 0; m_tgt = 4'd0;
      m_active = 0; m_first = 0; m_load = 0; m_judged = 1; m_hit = 0; m_miss = 0;
    end else begin
      m_hit = 0;
      m_miss = 0;
      if (song_start) begin
        m_active = 1; m_first = 1; m_load = 0; m_judged = 1; m_run = 0;
        m_score = 0; m_streak = 0; m_max = 0;
      end else if (m_active) begin
        if (m_load) begin
          m_tgt = next_notes[63:60];
          m_load = 0; m_judged = 0; m_run = 0;
        end else if (m_first) begin
          if (eighth_note_enable) begin
            m_first = 0;
            m_load = 1;
          end
        end else begin
          if (!m_judged) begin
            if (played_valid && played_note == m_tgt && m_tgt != 0) m_run++;
            else m_run = 0;
            if (m_run == HOLD) begin
              m_hit = 1;
              m_judged = 1;
              m_score = m_score + 10 * mult_of(m_streak);
              if (m_score > 65535) m_score = 65535;
              if (m_streak < 255) m_streak++;
              if (m_streak > m_max) m_max = m_streak;
            end
            if (eighth_note_enable && !m_judged && m_tgt != 0) begin
              m_miss = 1;
              m_streak = 0;
            end
          end
          if (eighth_note_enable) begin
            m_load = 1;
            m_judged = 1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("target_note", 32'(target_note), 32'(m_tgt));
      check("hit_pulse", 32'(hit_pulse), 32'(m_hit));
      check("miss_pulse", 32'(miss_pulse), 32'(m_miss));
      check("score", 32'(score), 32'(m_score));
      check("streak", 32'(streak), 32'(m_streak));
      check("max_streak", 32'(max_streak), 32'(m_max));
      check("mult", 32'(mult), 32'(mult_of(m_streak)));
      if (hit_pulse) hit_seen++;
      if (miss_pulse) miss_seen++;
    end
  end

  task automatic tick(input logic ss, input logic s, input logic [3:0] top,
                      input logic v, input logic [3:0] p);
    song_start = ss;
    eighth_note_enable = s;
    if (s) next_notes = {top, $urandom(), 28'($urandom())};
    played_valid = v;
    played_note = p;
    @(negedge clk);
    song_start = 1'b0;
    eighth_note_enable = 1'b0;
  endtask

  // LOAD cycle then HOLD matching cycles: the hit pulse is visible on return.
  task automatic hit_slot(input logic [3:0] note);
    tick(0, 0, 4'd0, 0, 4'd0);
    for (int i = 0; i < HOLD; i++) tick(0, 0, 4'd0, 1, note);
  endtask

  function automatic logic [3:0] rnd_note();
    return 4'(1 + $urandom_range(0, 14));
  endfunction

  int h0, m0;
  logic [3:0] cur, nxt;

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 1: strobes while idle do nothing
    for (int i = 0; i < 8; i++) tick(0, i[0], 4'h3, 1, 4'h3);
    tick(0, 0, 4'd0, 0, 4'd0);
    check("idle_score", 32'(score), 0);
    check("idle_mult", 32'(mult), 1);
    check("idle_hits", hit_seen, 0);
    check("idle_miss", miss_seen, 0);

    // 2: first strobe unjudged, then a held 3 scores 10
    tick(1, 0, 4'd0, 0, 4'd0);
    tick(0, 1, 4'h3, 0, 4'd0);
    h0 = hit_seen;
    hit_slot(4'h3);
    check("t2_hit_now", 32'(hit_pulse), 1);
    tick(0, 0, 4'd0, 1, 4'h3);
    tick(0, 0, 4'd0, 1, 4'h3);
    check("t2_hit_once", hit_seen - h0, 1);
    check("t2_score", 32'(score), 10);
    check("t2_streak", 32'(streak), 1);

    // 3: short hold on 5 then silence -> miss after strobe
    tick(0, 1, 4'h5, 0, 4'd0);
    tick(0, 0, 4'd0, 0, 4'd0);
    for (int i = 0; i < 3; i++) tick(0, 0, 4'd0, 1, 4'h5);
    tick(0, 0, 4'd0, 1, 4'h0);
    tick(0, 0, 4'd0, 0, 4'h0);
    tick(0, 1, 4'h1, 0, 4'd0);
    check("t3_miss_pulse", 32'(miss_pulse), 1);
    check("t3_streak", 32'(streak), 0);
    check("t3_score", 32'(score), 10);

    // 4: nine hits -> mult 2 after eight, total 100; then a rest slot
    tick(1, 0, 4'd0, 0, 4'd0);
    cur = rnd_note();
    tick(0, 1, cur, 0, 4'd0);
    for (int k = 0; k < 9; k++) begin
      hit_slot(cur);
      tick(0, 0, 4'd0, 0, 4'd0);
      if (k == 7) check("t4_mult_after8", 32'(mult), 2);
      nxt = (k == 8) ? 4'd0 : rnd_note();
      tick(0, 1, nxt, 0, 4'd0);
      cur = nxt;
    end
    check("t4_score", 32'(score), 100);
    check("t4_streak", 32'(streak), 9);
    h0 = hit_seen; m0 = miss_seen;
    tick(0, 0, 4'd0, 0, 4'd0);
    for (int i = 0; i < 6; i++) tick(0, 0, 4'd0, 1, 4'(i));
    tick(0, 1, 4'h7, 0, 4'd0);
    tick(0, 0, 4'd0, 0, 4'd0);
    check("t4_rest_hits", hit_seen - h0, 0);
    check("t4_rest_miss", miss_seen - m0, 0);
    check("t4_rest_streak", 32'(streak), 9);

    // 5: hold completes on the strobe cycle (LOAD for 7 already consumed above)
    for (int i = 0; i < HOLD - 1; i++) tick(0, 0, 4'd0, 1, 4'h7);
    tick(0, 1, 4'h2, 1, 4'h7);
    check("t5_hit", 32'(hit_pulse), 1);
    check("t5_no_miss", 32'(miss_pulse), 0);
    check("t5_target_old", 32'(target_note), 7);
    tick(0, 0, 4'd0, 0, 4'd0);
    check("t5_target_new", 32'(target_note), 2);
    check("t5_score", 32'(score), 120);

    // random play, mostly following the model's target
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom()),
           ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 4) == 0) ? 4'($urandom()) : m_tgt);
    end

    // 6: saturate score and streak
    tick(1, 0, 4'd0, 0, 4'd0);
    cur = rnd_note();
    tick(0, 1, cur, 0, 4'd0);
    for (int k = 0; k < 1660; k++) begin
      hit_slot(cur);
      cur = rnd_note();
      tick(0, 1, cur, 0, 4'd0);
    end
    check("t6_score_clamp", 32'(score), 32'hFFFF);
    check("t6_streak_sat", 32'(streak), 255);
    check("t6_max_sat", 32'(max_streak), 255);
    check("t6_mult_cap", 32'(mult), 4);

    // song_start mid-hold clears everything and waits for a strobe
    tick(0, 0, 4'd0, 0, 4'd0);
    tick(0, 0, 4'd0, 1, cur);
    tick(0, 0, 4'd0, 1, cur);
    tick(1, 0, 4'd0, 1, cur);
    check("t6_ss_score", 32'(score), 0);
    check("t6_ss_streak", 32'(streak), 0);
    check("t6_ss_max", 32'(max_streak), 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 4'd0, 1, cur);
    check("t6_ss_nohit", 32'(score), 0);
    tick(0, 1, 4'h4, 0, 4'd0);
    hit_slot(4'h4);
    tick(0, 0, 4'd0, 0, 4'd0);
    check("t6_restart_score", 32'(score), 10);

    // async reset mid-hold
    tick(0, 1, 4'h6, 0, 4'd0);
    tick(0, 0, 4'd0, 0, 4'd0);
    tick(0, 0, 4'd0, 1, 4'h6);
    played_valid = 1'b1; played_note = 4'h6;
    #2 reset = 1'b0;
    #1;
    check("rst_target", 32'(target_note), 0);
    check("rst_score", 32'(score), 0);
    check("rst_streak", 32'(streak), 0);
    check("rst_max", 32'(max_streak), 0);
    check("rst_mult", 32'(mult), 1);
    check("rst_hit", 32'(hit_pulse), 0);
    @(negedge clk);
    reset = 1'b1;
    tick(0, 0, 4'd0, 0, 4'd0);
    tick(0, 0, 4'd0, 0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
